// File: rtl/mem_pkg.sv
// Shared definitions for the RAM port arbiter: command codes, FSM states, grant ids.
// Pure declarations, no latency.
// No flow control of its own.
package mem_pkg;

  // RAM / bus command encoding (11 is treated as no command)
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } arb_state_t;

  // Which master owns the RAM port
  typedef enum logic {
    G_CPU = 1'b0,
    G_IO  = 1'b1
  } grant_t;

  // A command asks for the RAM only when it is a real read or write
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Read-latency down-counter: load a start value, decrement to zero, flag zero.
// Count updates one cycle after load/dec; zero flag is combinational from the count.
// No backpressure; saturates at zero if decremented further.
module mem_lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] count;

  // Load has priority over decrement; never wraps below zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign zero = (count == 3'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU and an IO/DMA master, one whole transaction at a time.
// Latency: grant edge, then RD_LAT+1 cycles of ram_cmd, then a one-cycle ack (min 4 cycles per transfer).
// Losers see no ack (CPU also sees cpu_wait); requests are only re-arbitrated from IDLE, round-robin.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW     = 9,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_cmd,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  input  logic          io_req,
  input  logic [1:0]    io_cmd,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_wdata,
  output logic          io_ack,
  output logic [DW-1:0] rdata,
  output logic [1:0]    ram_cmd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  // WAIT lasts RD_LAT cycles, so the counter starts one below the latency
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  arb_state_t state;
  grant_t     owner;
  grant_t     last_grant;

  logic cpu_req;
  logic io_valid;
  logic pick_io;
  logic lat_zero;

  // An IO request with a non-command code is simply not a request
  assign cpu_req  = is_req(cpu_cmd);
  assign io_valid = io_req && is_req(io_cmd);

  // Round-robin: on contention the master that did not win last time goes next
  always_comb begin
    pick_io = 1'b0;
    if (cpu_req && io_valid) begin
      pick_io = (last_grant == G_CPU);
    end else begin
      pick_io = io_valid;
    end
  end

  // CPU is stalled whenever it asks and is not the master currently holding the port
  assign cpu_wait = cpu_req && !((owner == G_CPU) && (state != IDLE));

  mem_lat_counter u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ISSUE),
    .load_val (LAT_LOAD),
    .dec      (state == WAIT),
    .zero     (lat_zero)
  );

  // Transaction FSM: grant and capture in IDLE, hold the RAM command, then ack and release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= G_CPU;
      last_grant <= G_IO;
      ram_cmd    <= MNONE;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rdata      <= '0;
      cpu_ack    <= 1'b0;
      io_ack     <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      io_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || io_valid) begin
            state <= ISSUE;
            if (pick_io) begin
              owner      <= G_IO;
              last_grant <= G_IO;
              ram_cmd    <= io_cmd;
              ram_addr   <= io_addr;
              ram_wdata  <= io_wdata;
            end else begin
              owner      <= G_CPU;
              last_grant <= G_CPU;
              ram_cmd    <= cpu_cmd;
              ram_addr   <= cpu_addr;
              ram_wdata  <= cpu_wdata;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (lat_zero) begin
            state   <= DONE;
            ram_cmd <= MNONE;
            // Writes leave rdata alone; only a read refreshes it
            if (ram_cmd == MREAD) begin
              rdata <= ram_rdata;
            end
            if (owner == G_CPU) begin
              cpu_ack <= 1'b1;
            end else begin
              io_ack <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ram_cmd <= MNONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two DUTs (RD_LAT 1 and 3) share one stimulus stream.
// Each has its own latency-accurate RAM and a transaction-level reference model.
// Directed scenarios pin the model with literal values, then random traffic runs.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]    cpu_cmd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          io_req;
  logic [1:0]    io_cmd;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_wdata;

  logic          cpu_ack   [2];
  logic          cpu_wait  [2];
  logic          io_ack    [2];
  logic [DW-1:0] rdata     [2];
  logic [1:0]    ram_cmd   [2];
  logic [AW-1:0] ram_addr  [2];
  logic [DW-1:0] ram_wdata [2];
  logic [DW-1:0] ram_rdata [2];

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 5) ? 16'hBEEF : 16'(16'h1000 + a);
  endfunction

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack[0]), .cpu_wait(cpu_wait[0]),
    .io_req(io_req), .io_cmd(io_cmd), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack[0]), .rdata(rdata[0]),
    .ram_cmd(ram_cmd[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_rdata(ram_rdata[0])
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack[1]), .cpu_wait(cpu_wait[1]),
    .io_req(io_req), .io_cmd(io_cmd), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack[1]), .rdata(rdata[1]),
    .ram_cmd(ram_cmd[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_rdata(ram_rdata[1])
  );

  // ---------------- RAM with read latency (one per DUT) ----------------
  logic [DW-1:0] mem  [2][512];
  logic [DW-1:0] pipe [2][3];
  bit ram_inited = 1'b0;

  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int k = 0; k < 2; k++) begin
        for (int a = 0; a < 512; a++) mem[k][a] <= init_val(a);
        for (int s = 0; s < 3; s++) pipe[k][s] <= 16'hDEAD;
      end
      ram_inited <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ram_cmd[k] == MWRITE) mem[k][ram_addr[k]] <= ram_wdata[k];
        pipe[k][0] <= (ram_cmd[k] == MREAD) ? mem[k][ram_addr[k]] : 16'hDEAD;
        pipe[k][1] <= pipe[k][0];
        pipe[k][2] <= pipe[k][1];
      end
    end
  end

  assign ram_rdata[0] = pipe[0][0];
  assign ram_rdata[1] = pipe[1][2];

  // ---------------- transaction-level reference model ----------------
  // age 0: port free; 1..lat+1: command on the RAM; lat+2: completion cycle
  int            m_age     [2];
  bit            m_io      [2];
  bit            m_last_io [2];
  logic [1:0]    m_cmd     [2];
  logic [AW-1:0] m_addr    [2];
  logic [DW-1:0] m_wdata   [2];
  logic [DW-1:0] m_rdata   [2];
  logic [DW-1:0] m_mem     [2][512];
  bit m_inited = 1'b0;

  task automatic model_step(input int k);
    int lat;
    bit cr, ir, pick_io;
    lat = lat_of(k);
    cr  = is_req(cpu_cmd);
    ir  = io_req && is_req(io_cmd);
    if (m_age[k] == 0) begin
      if (cr || ir) begin
        pick_io      = (cr && ir) ? !m_last_io[k] : ir;
        m_last_io[k] = pick_io;
        m_io[k]      = pick_io;
        m_cmd[k]     = pick_io ? io_cmd   : cpu_cmd;
        m_addr[k]    = pick_io ? io_addr  : cpu_addr;
        m_wdata[k]   = pick_io ? io_wdata : cpu_wdata;
        m_age[k]     = 1;
      end
    end else if (m_age[k] == lat + 2) begin
      m_age[k] = 0;
    end else begin
      m_age[k] = m_age[k] + 1;
      if (m_age[k] == lat + 2) begin
        if (m_cmd[k] == MREAD) m_rdata[k] = m_mem[k][m_addr[k]];
        else                   m_mem[k][m_addr[k]] = m_wdata[k];
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (!m_inited) for (int a = 0; a < 512; a++) m_mem[k][a] = init_val(a);
        m_age[k]     = 0;
        m_io[k]      = 1'b0;
        m_last_io[k] = 1'b1;
        m_rdata[k]   = '0;
      end
      m_inited = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_print < 60) begin
        n_print++;
        $display("FAIL %s dut%0d t=%0t: got %h, expected %h", name, k, $time, act, exp);
      end
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (reset === 1'b1 && m_inited) begin
      for (int k = 0; k < 2; k++) begin
        int  lat;
        bit  xfer;
        lat  = lat_of(k);
        xfer = (m_age[k] >= 1) && (m_age[k] <= lat + 1);
        check("ram_cmd", k, 32'(ram_cmd[k]), xfer ? 32'(m_cmd[k]) : 32'(MNONE));
        if (xfer) begin
          check("ram_addr", k, 32'(ram_addr[k]), 32'(m_addr[k]));
          check("ram_wdata", k, 32'(ram_wdata[k]), 32'(m_wdata[k]));
        end
        check("cpu_ack", k, 32'(cpu_ack[k]), 32'((m_age[k] == lat + 2) && !m_io[k]));
        check("io_ack", k, 32'(io_ack[k]), 32'((m_age[k] == lat + 2) && m_io[k]));
        check("rdata", k, 32'(rdata[k]), 32'(m_rdata[k]));
        check("cpu_wait", k, 32'(cpu_wait[k]),
              32'(is_req(cpu_cmd) && !((m_age[k] != 0) && !m_io[k])));
      end
    end
  end

  task automatic drive_idle();
    cpu_cmd = MNONE; cpu_addr = '0; cpu_wdata = '0;
    io_req = 1'b0; io_cmd = MNONE; io_addr = '0; io_wdata = '0;
  endtask

  // ---------------- stimulus and literal expectations ----------------
  initial begin
    int got[$];
    int exp_order[4];
    int acks;
    drive_idle();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Reset state
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_ram_cmd", k, 32'(ram_cmd[k]), 32'h0);
      check("rst_ram_addr", k, 32'(ram_addr[k]), 32'h0);
      check("rst_ram_wdata", k, 32'(ram_wdata[k]), 32'h0);
      check("rst_rdata", k, 32'(rdata[k]), 32'h0);
      check("rst_acks", k, 32'({cpu_ack[k], io_ack[k]}), 32'h0);
    end

    // Continuous contention: C, I, C, I with cpu_wait high during IO turns
    @(posedge clk); #1;
    cpu_cmd = MREAD; cpu_addr = 9'h001;
    io_req = 1'b1; io_cmd = MWRITE; io_addr = 9'h003; io_wdata = 16'h7777;
    exp_order = '{0, 1, 0, 1};
    for (int c = 0; c < 60 && got.size() < 4; c++) begin
      @(negedge clk);
      if (cpu_ack[0]) got.push_back(0);
      if (io_ack[0]) begin
        got.push_back(1);
        check("t4_cpu_wait_io_turn", 0, 32'(cpu_wait[0]), 32'h1);
      end
    end
    check("t4_ack_count", 0, 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("t4_grant_order", 0, 32'(got[i]), 32'(exp_order[i]));
    @(posedge clk); #1 drive_idle();
    repeat (12) @(posedge clk);

    // CPU read of 0x005 (BEEF), with a bogus IO code that must never be acked
    #1;
    cpu_cmd = MREAD; cpu_addr = 9'h005;
    io_req = 1'b1; io_cmd = 2'b11; io_addr = 9'h007;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) for (int k = 0; k < 2; k++) check("t2_wait_c0", k, 32'(cpu_wait[k]), 32'h1);
      if (c >= 1 && c <= 3) begin
        check("t2_ram_cmd", 0, 32'(ram_cmd[0]), (c <= 2) ? 32'(MREAD) : 32'(MNONE));
        check("t2_cpu_ack", 0, 32'(cpu_ack[0]), 32'(c == 3));
      end
      if (c >= 1 && c <= 5) begin
        check("t6_ram_cmd", 1, 32'(ram_cmd[1]), (c <= 4) ? 32'(MREAD) : 32'(MNONE));
        check("t6_cpu_ack", 1, 32'(cpu_ack[1]), 32'(c == 5));
      end
      if (c == 3) check("t2_rdata", 0, 32'(rdata[0]), 32'hBEEF);
      if (c == 5) check("t6_rdata", 1, 32'(rdata[1]), 32'hBEEF);
      for (int k = 0; k < 2; k++) check("t6_no_io_ack", k, 32'(io_ack[k]), 32'h0);
    end
    drive_idle();
    repeat (12) @(posedge clk);

    // IO write alone: 0x1F0 <= 0x1234, rdata untouched
    #1;
    io_req = 1'b1; io_cmd = MWRITE; io_addr = 9'h1F0; io_wdata = 16'h1234;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 2) begin
        check("t3_ram_cmd", 0, 32'(ram_cmd[0]), 32'(MWRITE));
        check("t3_ram_addr", 0, 32'(ram_addr[0]), 32'h1F0);
        check("t3_ram_wdata", 0, 32'(ram_wdata[0]), 32'h1234);
      end
      check("t3_io_ack", 0, 32'(io_ack[0]), 32'(c == 3));
    end
    check("t3_rdata_kept", 0, 32'(rdata[0]), 32'hBEEF);
    drive_idle();
    repeat (12) @(posedge clk);

    // IO read whose address changes after grant
    #1;
    io_req = 1'b1; io_cmd = MREAD; io_addr = 9'h010;
    @(posedge clk); #1 io_addr = 9'h020;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 2) check("t5_ram_addr", 0, 32'(ram_addr[0]), 32'h010);
      if (c <= 4) check("t5_ram_addr", 1, 32'(ram_addr[1]), 32'h010);
      if (c == 3) check("t5_rdata", 0, 32'(rdata[0]), 32'h1010);
      if (c == 5) check("t5_rdata", 1, 32'(rdata[1]), 32'h1010);
      if (c == 3) drive_idle();
    end
    repeat (12) @(posedge clk);

    // Reset in the middle of a CPU read
    #1;
    cpu_cmd = MREAD; cpu_addr = 9'h002;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("t1_ram_cmd_async", k, 32'(ram_cmd[k]), 32'h0);
      check("t1_rdata_async", k, 32'(rdata[k]), 32'h0);
    end
    drive_idle();
    @(posedge clk); #2 reset = 1'b1;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cpu_ack[0] || cpu_ack[1]) acks++;
    end
    check("t1_no_ack_after_reset", 0, 32'(acks), 32'h0);

    // Random traffic on a small address set to exercise read-after-write
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      cpu_cmd   = 2'($urandom_range(0, 3));
      cpu_addr  = ($urandom_range(0, 7) == 0) ? 9'h1F0 : 9'($urandom_range(0, 15));
      cpu_wdata = 16'($urandom);
      io_req    = ($urandom_range(0, 2) != 0);
      io_cmd    = 2'($urandom_range(0, 3));
      io_addr   = ($urandom_range(0, 7) == 0) ? 9'h1F0 : 9'($urandom_range(0, 15));
      io_wdata  = 16'($urandom);
    end
    @(posedge clk); #1 drive_idle();
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
